// File: rtl/v4_fsm_pkg.sv
// rtl/v4_fsm_pkg.sv - shared types and constants for the three demo FSMs
package v4_fsm_pkg;

  typedef enum logic [1:0] {
    LIGHT_OFF  = 2'b00,
    LIGHT_LOW  = 2'b01,
    LIGHT_MED  = 2'b10,
    LIGHT_HIGH = 2'b11
  } light_t;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

  localparam logic [3:0] LED_RESET = 4'b0001;

  // OFF -> LOW -> MED -> HIGH -> OFF
  function automatic light_t light_next(input light_t cur);
    return light_t'(cur + 2'd1);
  endfunction

endpackage

// File: rtl/seq_detect_011.sv
// rtl/seq_detect_011.sv - overlapping Moore detector for the serial pattern 0,1,1
module seq_detect_011
  import v4_fsm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic bit_in,
  output logic detect
);

  det_state_t r_state;
  logic       r_detect;

  // r_detect is loaded with (next state == S3) so it always equals (r_state == S3)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S0;
      r_detect <= 1'b0;
    end else begin
      r_detect <= 1'b0;
      case (r_state)
        S0: r_state <= bit_in ? S0 : S1;
        S1: r_state <= bit_in ? S2 : S1;
        S2: begin
          if (bit_in) begin
            r_state  <= S3;
            r_detect <= 1'b1;
          end else begin
            r_state <= S1;
          end
        end
        S3: r_state <= bit_in ? S0 : S1;
        default: r_state <= S0;
      endcase
    end
  end

  assign detect = r_detect;

endmodule

// File: rtl/v4_fsm_top.sv
// rtl/v4_fsm_top.sv - light cycler, 011 detector and LED rotator sharing one clock
module v4_fsm_top
  import v4_fsm_pkg::*;
#(
  parameter int LED_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       click,
  input  logic       bit_in,
  output logic [1:0] light_out,
  output logic       detect,
  output logic [3:0] leds
);

  localparam logic [15:0] DIV_LAST = 16'(LED_DIV - 1);

  light_t      r_light;
  logic        r_click_q;
  logic [15:0] r_div_cnt;
  logic [3:0]  r_leds;
  logic        w_press;
  logic        w_detect;

  assign w_press = click & ~r_click_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_light   <= LIGHT_OFF;
      r_click_q <= 1'b0;
    end else begin
      r_click_q <= click;
      if (w_press) begin
        r_light <= light_next(r_light);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt <= 16'd0;
      r_leds    <= LED_RESET;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= 16'd0;
      r_leds    <= {r_leds[2:0], r_leds[3]};
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  seq_detect_011 u_seq_detect (
    .clk    (clk),
    .rst    (rst),
    .bit_in (bit_in),
    .detect (w_detect)
  );

  assign light_out = r_light;
  assign detect    = w_detect;
  assign leds      = r_leds;

endmodule

// File: tb/tb_v4_fsm_top.sv
// tb/tb_v4_fsm_top.sv - directed-vector bench for v4_fsm_top
module tb_v4_fsm_top;

  logic       clk = 1'b0;
  logic       rst;
  logic       click;
  logic       bit_in;
  logic [1:0] light_out, light_out1;
  logic       detect, detect1;
  logic [3:0] leds, leds1;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  v4_fsm_top #(.LED_DIV(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .click     (click),
    .bit_in    (bit_in),
    .light_out (light_out),
    .detect    (detect),
    .leds      (leds)
  );

  v4_fsm_top #(.LED_DIV(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .click     (click),
    .bit_in    (bit_in),
    .light_out (light_out1),
    .detect    (detect1),
    .leds      (leds1)
  );

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    click  = 1'b0;
    bit_in = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    logic [9:0] pat_a;
    logic [9:0] exp_a;
    logic [6:0] pat_n;
    logic [4:0] pat_b;
    logic [3:0] exp_leds;

    rst    = 1'b1;
    click  = 1'b0;
    bit_in = 1'b0;
    step();
    step();
    chk_vec("rst_light", 32'(light_out), 32'h0);
    chk_vec("rst_detect", 32'(detect), 32'h0);
    chk_vec("rst_leds", 32'(leds), 32'h1);
    chk_vec("rst_leds_div1", 32'(leds1), 32'h1);

    // n = edges since reset release; rotations = n / LED_DIV
    rst = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      step();
      exp_leds = 4'b0001 << ((n / 4) % 4);
      chk_vec($sformatf("leds_div4_e%0d", n), 32'(leds), 32'(exp_leds));
      exp_leds = 4'b0001 << (n % 4);
      chk_vec($sformatf("leds_div1_e%0d", n), 32'(leds1), 32'(exp_leds));
    end

    do_reset();
    for (int p = 1; p <= 4; p++) begin
      click = 1'b1;
      step();
      chk_vec($sformatf("press%0d_hi", p), 32'(light_out), 32'(p % 4));
      click = 1'b0;
      step();
      chk_vec($sformatf("press%0d_lo", p), 32'(light_out), 32'(p % 4));
    end
    click = 1'b1;
    step();
    chk_vec("hold_first", 32'(light_out), 32'h1);
    repeat (4) step();
    chk_vec("hold_five", 32'(light_out), 32'h1);
    click = 1'b0;
    step();
    chk_vec("hold_release", 32'(light_out), 32'h1);

    rst   = 1'b1;
    click = 1'b1;
    step();
    step();
    chk_vec("click_in_rst", 32'(light_out), 32'h0);
    rst = 1'b0;
    step();
    chk_vec("click_at_release", 32'(light_out), 32'h1);
    step();
    chk_vec("click_at_release_hold", 32'(light_out), 32'h1);
    click = 1'b0;

    // bits applied MSB first: 0,1,1,0,0,1,1,0,1,1
    pat_a = 10'b0110011011;
    exp_a = 10'b0010001001;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bit_in = pat_a[9 - i];
      step();
      chk_vec($sformatf("det_a_%0d", i), 32'(detect), 32'(exp_a[9 - i]));
    end

    pat_n = 7'b1110101;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      bit_in = pat_n[6 - i];
      step();
      chk_vec($sformatf("det_neg_%0d", i), 32'(detect), 32'h0);
    end

    pat_b = 5'b01111;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bit_in = pat_b[4 - i];
      step();
      chk_vec($sformatf("det_b_%0d", i), 32'(detect), (i == 2) ? 32'h1 : 32'h0);
    end

    do_reset();
    bit_in = 1'b1;
    for (int p = 0; p < 2; p++) begin
      click = 1'b1;
      step();
      click = 1'b0;
      step();
    end
    chk_vec("mid_light_pre", 32'(light_out), 32'h2);
    bit_in = 1'b0;
    step();
    bit_in = 1'b1;
    step();
    chk_vec("mid_detect_pre", 32'(detect), 32'h0);
    rst    = 1'b1;
    bit_in = 1'b1;
    step();
    chk_vec("mid_rst_light", 32'(light_out), 32'h0);
    chk_vec("mid_rst_detect", 32'(detect), 32'h0);
    chk_vec("mid_rst_leds", 32'(leds), 32'h1);
    rst = 1'b0;
    step();
    chk_vec("mid_post_1", 32'(detect), 32'h0);
    step();
    chk_vec("mid_post_2", 32'(detect), 32'h0);
    chk_vec("mid_post_light", 32'(light_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
